// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit: narrows rt to byte/half/word, places it on memory byte lanes
// and runs the write handshake. Define STORE_SPLIT_EN to split unaligned stores into two beats.
module store_narrow_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Store_Valid,
    output logic                  Store_Ready,
    input  logic [ADDR_WIDTH-1:0] Store_Addr,
    input  logic [DATA_WIDTH-1:0] Store_Data,
    input  logic [1:0]            Store_Size,
    output logic                  Mem_Req,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [DATA_WIDTH-1:0] Mem_WData,
    output logic [3:0]            Mem_Byte_En,
    input  logic                  Mem_Ack,
    output logic                  Store_Done,
    output logic                  Store_Fault
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ1,
        REQ2,
        RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_size;
    logic                    r_fault;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_be;

    logic [1:0]              w_k;
    logic [3:0]              w_size_mask;
    logic [DATA_WIDTH-1:0]   w_rep;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [3:0]              w_be1;
    logic                    w_fault;

    assign w_k = r_addr[1:0];

    always_comb begin
        w_rep       = r_data;
        w_size_mask = 4'b0000;
        case (r_size)
            2'b00: begin
                w_rep       = {4{r_data[7:0]}};
                w_size_mask = 4'b0001;
            end
            2'b01: begin
                w_rep       = {2{r_data[15:0]}};
                w_size_mask = 4'b0011;
            end
            2'b10: begin
                w_rep       = r_data;
                w_size_mask = 4'b1111;
            end
            default: begin
                w_rep       = r_data;
                w_size_mask = 4'b0000;
            end
        endcase
    end

    // Rotate-left by whole bytes so the low-order datum lands on lane k.
    always_comb begin
        w_wdata = w_rep;
        case (w_k)
            2'd1:    w_wdata = {w_rep[23:0], w_rep[31:24]};
            2'd2:    w_wdata = {w_rep[15:0], w_rep[31:16]};
            2'd3:    w_wdata = {w_rep[7:0],  w_rep[31:8]};
            default: w_wdata = w_rep;
        endcase
    end

`ifdef STORE_SPLIT_EN
    logic [7:0] w_lanes;
    logic [3:0] w_be2;
    logic [3:0] r_be2;

    // Low nibble is beat 1, anything spilling past lane 3 belongs to the next word.
    assign w_lanes = {4'b0000, w_size_mask} << w_k;
    assign w_be1   = w_lanes[3:0];
    assign w_be2   = w_lanes[7:4];
    assign w_fault = (r_size == 2'b11);
`else
    assign w_be1   = w_size_mask << w_k;
    assign w_fault = (r_size == 2'b11)
                   || ((r_size == 2'b01) && r_addr[0])
                   || ((r_size == 2'b10) && (w_k != 2'd0));
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (Store_Valid) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = w_fault ? RESP : REQ1;
            end
            REQ1: begin
                if (Mem_Ack) begin
`ifdef STORE_SPLIT_EN
                    w_next = (r_be2 != 4'b0000) ? REQ2 : RESP;
`else
                    w_next = RESP;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            REQ2: begin
                if (Mem_Ack) begin
                    w_next = RESP;
                end
            end
`endif
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_size     <= '0;
            r_fault    <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
`ifdef STORE_SPLIT_EN
            r_be2      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (Store_Valid) begin
                        r_addr <= Store_Addr;
                        r_data <= Store_Data;
                        r_size <= Store_Size;
                    end
                end
                CHECK: begin
                    r_fault <= w_fault;
                    if (!w_fault) begin
                        r_mem_addr <= {r_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_be       <= w_be1;
`ifdef STORE_SPLIT_EN
                        r_be2      <= w_be2;
`endif
                    end
                end
                REQ1: begin
                    if (Mem_Ack) begin
`ifdef STORE_SPLIT_EN
                        if (r_be2 != 4'b0000) begin
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
                            r_be       <= r_be2;
                        end else begin
                            r_be <= '0;
                        end
`else
                        r_be <= '0;
`endif
                    end
                end
                REQ2: begin
                    if (Mem_Ack) begin
                        r_be <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Store_Ready = (r_state == IDLE);
    assign Mem_Req     = (r_state == REQ1) || (r_state == REQ2);
    assign Mem_Addr    = r_mem_addr;
    assign Mem_WData   = r_wdata;
    assign Mem_Byte_En = r_be;
    assign Store_Done  = (r_state == RESP) && !r_fault;
    assign Store_Fault = (r_state == RESP) && r_fault;

endmodule
